// File: rtl/acc_seq_pkg.sv
// Shared types for the accumulator sequencer: opcode and FSM state encodings
// plus small opcode-class helpers.
package acc_seq_pkg;

  localparam int RF_ADDR_W = 2;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    IMM,
    RDREG,
    EXEC,
    WRITE,
    HALT
  } state_t;

  function automatic logic has_imm(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic reads_reg(input logic [3:0] op);
    return (op == OP_LD) || is_alu(op);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator sequencer. Anything that is not an
// arithmetic/logic opcode passes operand b through with C cleared.
module acc_alu
  import acc_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // the extra top bit of the difference is the borrow (a < b)
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = b;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = b;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/acc_sequencer.sv
// Multi-cycle accumulator sequencer: fetches from a combinational program ROM
// and is the only writer of the downstream register file.
//
//   state  | meaning
//   IDLE   | waiting for START
//   FETCH  | IR <= ROM[PC], PC++
//   DECODE | latch RF_ADDR, branch on opcode
//   IMM    | operand <= ROM[PC], PC++
//   RDREG  | operand <= RF_OUT
//   EXEC   | apply the op to ACC/flags/PC
//   WRITE  | RF_EN high, RF_IN = ACC
//   HALT   | parked until reset
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic [PC_W-1:0]      PROG_ADDR,
  input  logic [DATA_W-1:0]    PROG_DATA,
  output logic                 RF_EN,
  output logic [RF_ADDR_W-1:0] RF_ADDR,
  output logic [DATA_W-1:0]    RF_IN,
  input  logic [DATA_W-1:0]    RF_OUT,
  output logic [DATA_W-1:0]    ACC_OUT,
  output logic [1:0]           FLAGS,
  output logic                 BUSY,
  output logic                 HALTED
);

  state_t                 state;
  logic [PC_W-1:0]        pc;
  logic [DATA_W-1:0]      ir;
  logic [DATA_W-1:0]      opnd;
  logic [DATA_W-1:0]      acc;
  logic                   z;
  logic                   c;
  logic                   rf_en;
  logic [RF_ADDR_W-1:0]   rf_addr;
  logic [DATA_W-1:0]      rf_in;
  logic                   busy;
  logic                   halted;

  logic [3:0]             op;
  logic [DATA_W-1:0]      alu_result;
  logic                   alu_c;
  logic                   alu_z;
  logic                   unused_ir_bits;

  assign op = ir[7:4];
  // IR[3:2] carry no meaning in this instruction set
  assign unused_ir_bits = ^ir[3:2];

  acc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (acc),
    .b      (opnd),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      opnd    <= '0;
      acc     <= '0;
      z       <= 1'b0;
      c       <= 1'b0;
      rf_en   <= 1'b0;
      rf_addr <= '0;
      rf_in   <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      rf_in <= acc;
      rf_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          ir    <= PROG_DATA;
          pc    <= pc + 1'b1;
          state <= DECODE;
        end
        DECODE: begin
          rf_addr <= ir[RF_ADDR_W-1:0];
          if (has_imm(op)) begin
            state <= IMM;
          end else if (reads_reg(op)) begin
            state <= RDREG;
          end else if (op == OP_ST) begin
            state <= WRITE;
            rf_en <= 1'b1;
          end else if (op == OP_HLT) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        IMM: begin
          opnd  <= PROG_DATA;
          pc    <= pc + 1'b1;
          state <= EXEC;
        end
        RDREG: begin
          opnd  <= RF_OUT;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          if ((op == OP_LDI) || (op == OP_LD)) begin
            acc <= alu_result;
            z   <= alu_z;
          end else if (is_alu(op)) begin
            acc <= alu_result;
            z   <= alu_z;
            c   <= alu_c;
          end else if ((op == OP_JMP) || ((op == OP_JZ) && z)) begin
            pc <= PC_W'(opnd);
          end
        end
        WRITE: begin
          state <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign PROG_ADDR = pc;
  assign RF_EN     = rf_en;
  assign RF_ADDR   = rf_addr;
  assign RF_IN     = rf_in;
  assign ACC_OUT   = acc;
  assign FLAGS     = {z, c};
  assign BUSY      = busy;
  assign HALTED    = halted;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: owns the program ROM and a 4-entry register file,
// runs a table of directed programs, hand-written corner sequences and random
// programs checked against an instruction-level model.
module tb_acc_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] PROG_ADDR;
  logic [7:0] PROG_DATA;
  logic       RF_EN;
  logic [1:0] RF_ADDR;
  logic [7:0] RF_IN;
  logic [7:0] RF_OUT;
  logic [7:0] ACC_OUT;
  logic [1:0] FLAGS;
  logic       BUSY;
  logic       HALTED;

  logic [7:0] rom     [256];
  logic [7:0] rf      [4];
  logic [7:0] rf_init [4];
  logic       rf_load = 1'b0;
  int         m_rf    [4];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [0:11][7:0] prog;
    logic [7:0]       acc;
    logic [1:0]       flags;
    logic [7:0]       pc;
    int               cyc;
    int               wr;
    logic [1:0]       wa;
    logic [7:0]       wd;
  } vec_t;

  vec_t vq[$];

  acc_sequencer #(.PC_W(8), .DATA_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .PROG_ADDR (PROG_ADDR),
    .PROG_DATA (PROG_DATA),
    .RF_EN     (RF_EN),
    .RF_ADDR   (RF_ADDR),
    .RF_IN     (RF_IN),
    .RF_OUT    (RF_OUT),
    .ACC_OUT   (ACC_OUT),
    .FLAGS     (FLAGS),
    .BUSY      (BUSY),
    .HALTED    (HALTED)
  );

  always #5 CLK = ~CLK;

  assign PROG_DATA = rom[PROG_ADDR];
  assign RF_OUT    = rf[RF_ADDR];

  always_ff @(posedge CLK) begin
    if (rf_load) begin
      for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
    end else if (RF_EN) begin
      rf[RF_ADDR] <= RF_IN;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    START   = 1'b0;
    rf_load = 1'b1;
    step();
    step();
    RST     = 1'b0;
    rf_load = 1'b0;
  endtask

  task automatic add_vec(input logic [0:11][7:0] prog, input logic [7:0] acc,
                         input logic [1:0] flags, input logic [7:0] pc,
                         input int cyc, input int wr, input logic [1:0] wa,
                         input logic [7:0] wd);
    vec_t v;
    v.prog = prog; v.acc = acc; v.flags = flags; v.pc = pc;
    v.cyc = cyc; v.wr = wr; v.wa = wa; v.wd = wd;
    vq.push_back(v);
  endtask

  // Pulse START, then count cycles until HALTED, watching every RF write.
  task automatic run_prog(input string tag, input int budget, output int cyc,
                          output int wr, output int last_wa, output int last_wd);
    bit prev_en = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    cyc = 0; wr = 0; last_wa = -1; last_wd = -1;
    while (!HALTED && cyc < budget) begin
      step();
      cyc++;
      if (RF_EN) begin
        wr++;
        last_wa = int'(RF_ADDR);
        last_wd = int'(RF_IN);
        check({tag, ".rf_in_is_acc"}, int'(RF_IN), int'(ACC_OUT));
        check({tag, ".rf_en_one_cycle"}, int'(prev_en), 0);
      end
      prev_en = RF_EN;
    end
    check({tag, ".halted"}, int'(HALTED), 1);
    check({tag, ".busy_low"}, int'(BUSY), 0);
  endtask

  // Instruction-level reference: one loop iteration per instruction.
  task automatic iss(output bit ok, output int acc, output int z, output int c,
                     output int pc, output int cyc, output int wr);
    int ins, op, r, v;
    acc = 0; z = 0; c = 0; pc = 0; cyc = 0; wr = 0; ok = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = int'(rf_init[i]);
    for (int s = 0; s < 400 && !ok; s++) begin
      ins = int'(rom[pc]);
      pc  = (pc + 1) % 256;
      op  = ins / 16;
      r   = ins % 4;
      case (op)
        1, 9, 10: begin
          v   = int'(rom[pc]);
          pc  = (pc + 1) % 256;
          cyc += 4;
          if (op == 1) begin
            acc = v;
            z   = (acc == 0);
          end else if (op == 9 || z == 1) begin
            pc = v;
          end
        end
        2: begin acc = m_rf[r]; z = (acc == 0); cyc += 4; end
        3: begin m_rf[r] = acc; wr++; cyc += 3; end
        4, 5, 6, 7, 8: begin
          v = m_rf[r];
          case (op)
            4: begin c = (acc + v > 255); acc = (acc + v) % 256; end
            5: begin c = (acc < v); acc = (acc - v + 256) % 256; end
            6: begin c = 0; acc = acc & v; end
            7: begin c = 0; acc = acc | v; end
            default: begin c = 0; acc = acc ^ v; end
          endcase
          z = (acc == 0);
          cyc += 4;
        end
        15: begin ok = 1'b1; cyc += 2; end
        default: cyc += 2;
      endcase
    end
  endtask

  function automatic logic [7:0] pick_imm();
    case ($urandom_range(0, 4))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h01;
      3: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic gen_prog();
    int a = 0;
    int n = int'($urandom_range(3, 18));
    int op;
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    for (int k = 0; k < n; k++) begin
      op = int'($urandom_range(0, 15));
      rom[a] = 8'(op * 16 + int'($urandom_range(0, 15)));
      if (op == 1) begin
        rom[a + 1] = pick_imm();
        a += 2;
      end else if (op == 9 || op == 10) begin
        rom[a + 1] = 8'(a + 2 + int'($urandom_range(0, 6)));
        a += 2;
      end else begin
        a += 1;
      end
    end
  endtask

  initial begin
    int cyc, wr, wa, wd, budget, found;
    int e_acc, e_z, e_c, e_pc, e_cyc, e_wr;
    bit ok;
    string tag;
    RST = 1'b1;
    START = 1'b0;

    // Reset and start from cold.
    for (int i = 0; i < 4; i++) rf_init[i] = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    do_reset();
    check("rst.prog_addr", int'(PROG_ADDR), 0);
    check("rst.rf_en", int'(RF_EN), 0);
    check("rst.acc", int'(ACC_OUT), 0);
    check("rst.flags", int'(FLAGS), 0);
    step(); step(); step();
    check("idle.busy", int'(BUSY), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    check("start.busy", int'(BUSY), 1);
    check("start.prog_addr", int'(PROG_ADDR), 0);
    check("start.halted", int'(HALTED), 0);

    // Directed programs: bytes, ACC, {Z,C}, final PC, cycles, writes, last write.
    add_vec({8'h10, 8'hAA, 8'h31, 8'h10, 8'h00, 8'h21, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'hAA, 2'b00, 8'h07, 17, 1, 2'd1, 8'hAA);
    add_vec({8'h10, 8'hFF, 8'h30, 8'h10, 8'h01, 8'h40, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'h00, 2'b11, 8'h07, 17, 1, 2'd0, 8'hFF);
    add_vec({8'h10, 8'hFF, 8'h30, 8'h10, 8'h01, 8'h40, 8'h50, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'h01, 2'b01, 8'h08, 21, 1, 2'd0, 8'hFF);
    add_vec({8'h10, 8'h00, 8'hA0, 8'h10, 8'h10, 8'h55, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'h00, 2'b10, 8'h11, 10, 0, 2'd0, 8'h00);
    add_vec({8'h10, 8'h01, 8'hA0, 8'h10, 8'h10, 8'h55, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'h55, 2'b00, 8'h07, 14, 0, 2'd0, 8'h00);
    add_vec({8'h10, 8'hFF, 8'h30, 8'h10, 8'h01, 8'h40, 8'hB3, 8'h00, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'h00, 2'b11, 8'h09, 21, 1, 2'd0, 8'hFF);
    add_vec({8'h10, 8'hFF, 8'h32, 8'h10, 8'h01, 8'h42, 8'h10, 8'hF0, 8'h62, 8'h82, 8'h72, 8'hF0},
            8'hFF, 2'b00, 8'h0C, 33, 1, 2'd2, 8'hFF);
    add_vec({8'h10, 8'hFF, 8'h30, 8'h10, 8'h01, 8'h40, 8'h10, 8'h05, 8'hF0, 8'hF0, 8'hF0, 8'hF0},
            8'h05, 2'b01, 8'h09, 21, 1, 2'd0, 8'hFF);
    add_vec({8'h10, 8'h3C, 8'h33, 8'h10, 8'h00, 8'h23, 8'h90, 8'h0A, 8'hF0, 8'hF0, 8'h10, 8'h81},
            8'h81, 2'b00, 8'h0D, 25, 1, 2'd3, 8'h3C);

    foreach (vq[k]) begin
      tag = $sformatf("vec%0d", k);
      for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
      for (int i = 0; i < 12; i++) rom[i] = vq[k].prog[i];
      do_reset();
      run_prog(tag, vq[k].cyc + 20, cyc, wr, wa, wd);
      check({tag, ".cycles"}, cyc, vq[k].cyc);
      check({tag, ".acc"}, int'(ACC_OUT), int'(vq[k].acc));
      check({tag, ".flags"}, int'(FLAGS), int'(vq[k].flags));
      check({tag, ".pc"}, int'(PROG_ADDR), int'(vq[k].pc));
      check({tag, ".writes"}, wr, vq[k].wr);
      if (vq[k].wr > 0) begin
        check({tag, ".wr_addr"}, wa, int'(vq[k].wa));
        check({tag, ".wr_data"}, wd, int'(vq[k].wd));
      end
    end

    // START while halted is ignored; reset then clears everything.
    START = 1'b1;
    step();
    START = 1'b0;
    step(); step();
    check("halt.start_ignored", int'(HALTED), 1);
    check("halt.busy", int'(BUSY), 0);
    check("halt.pc_held", int'(PROG_ADDR), 8'h0D);
    do_reset();
    check("rst2.prog_addr", int'(PROG_ADDR), 0);
    check("rst2.acc", int'(ACC_OUT), 0);
    check("rst2.flags", int'(FLAGS), 0);
    check("rst2.rf_in", int'(RF_IN), 0);
    check("rst2.rf_addr", int'(RF_ADDR), 0);
    check("rst2.halted", int'(HALTED), 0);
    check("rst2.busy", int'(BUSY), 0);

    // Reset landing in the WRITE cycle of ST R2.
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    rom[0] = 8'h10; rom[1] = 8'h77; rom[2] = 8'h32;
    do_reset();
    START = 1'b1;
    step();
    START = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (RF_EN) found = i + 1;
    end
    check("midwr.write_cycle", found, 6);
    check("midwr.rf_addr", int'(RF_ADDR), 2);
    check("midwr.rf_in", int'(RF_IN), 8'h77);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midwr.rf_en", int'(RF_EN), 0);
    check("midwr.busy", int'(BUSY), 0);
    check("midwr.pc", int'(PROG_ADDR), 0);
    check("midwr.acc", int'(ACC_OUT), 0);
    step(); step();
    check("midwr.stays_idle", int'(BUSY), 0);

    // JMP 0xFF onto an LDI whose operand wraps to address 0x00.
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    rom[0] = 8'h90; rom[1] = 8'hFF; rom[255] = 8'h10;
    do_reset();
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("wrap.jmp_target", int'(PROG_ADDR), 8'hFF);
    step(); step();
    check("wrap.operand_addr", int'(PROG_ADDR), 8'h00);
    step(); step();
    check("wrap.pc_after_ldi", int'(PROG_ADDR), 8'h01);
    check("wrap.acc", int'(ACC_OUT), 8'h90);
    step(); step();
    check("wrap.halted", int'(HALTED), 1);
    check("wrap.final_pc", int'(PROG_ADDR), 8'h02);

    // Random programs against the instruction-level model.
    for (int t = 0; t < 40; t++) begin
      int tries = 0;
      ok = 1'b0;
      while (!ok && tries < 20) begin
        gen_prog();
        for (int i = 0; i < 4; i++) rf_init[i] = 8'($urandom);
        iss(ok, e_acc, e_z, e_c, e_pc, e_cyc, e_wr);
        tries++;
      end
      if (ok) begin
        tag = $sformatf("rnd%0d", t);
        do_reset();
        budget = e_cyc + 20;
        run_prog(tag, budget, cyc, wr, wa, wd);
        check({tag, ".cycles"}, cyc, e_cyc);
        check({tag, ".acc"}, int'(ACC_OUT), e_acc);
        check({tag, ".flags"}, int'(FLAGS), e_z * 2 + e_c);
        check({tag, ".pc"}, int'(PROG_ADDR), e_pc);
        check({tag, ".writes"}, wr, e_wr);
        for (int i = 0; i < 4; i++)
          check($sformatf("%s.rf%0d", tag, i), int'(rf[i]), m_rf[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
